// File: rtl/im_responder_pkg.sv
// im_responder_pkg
// Shared definitions for the instruction-memory responder: the fetch FSM
// state encoding, the default code-segment base address, and the default
// memory depth and response latency.
// Ports: none (package).
// Optional feature macro used by importers: IM_FETCH_CHECK_EN.
package im_responder_pkg;

  localparam int          DEF_DEPTH   = 1024;
  localparam logic [31:0] CODE_SEG_PC = 32'h0000_3000;
  localparam int          DEF_LATENCY = 2;

  // Wait counter width; holds latencies 0..15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

endpackage

// File: rtl/im_responder_array.sv
// im_array
// DEPTH x 32 instruction storage with one synchronous write port and one
// asynchronous read port. Contents are never reset.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write word index
//   wdata  - write data
//   raddr  - read word index
//   rdata  - read data (combinational from raddr)
module im_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Program-load write port; memory deliberately has no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The read sees contents from before any write on the same edge.
  assign rdata = mem[raddr];

endmodule

// File: rtl/im_responder.sv
// im_responder
// Instruction-memory fetch responder. Accepts one fetch at a time from the
// IFU, waits LATENCY cycles, then presents the addressed word for one cycle.
// Optional macro IM_FETCH_CHECK_EN adds the err output and fetch-fault
// detection (misaligned, below BASE, or beyond DEPTH words).
// Ports:
//   clk       - sole clock, rising edge
//   reset     - synchronous active-low reset
//   req       - fetch request, accepted when ready
//   addr      - fetch byte address, sampled on acceptance
//   ready     - responder idle and able to accept
//   rvalid    - one-cycle pulse, rdata valid
//   rdata     - fetched instruction word, held until next response
//   prog_we   - program-load write enable (works in any state and in reset)
//   prog_addr - program-load word index
//   prog_data - program-load word
//   err       - fault flag pulsing with rvalid (IM_FETCH_CHECK_EN only)
module im_responder
  import im_responder_pkg::*;
#(
  parameter int          DEPTH   = DEF_DEPTH,
  parameter logic [31:0] BASE    = CODE_SEG_PC,
  parameter int          LATENCY = DEF_LATENCY,
  localparam int         AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [31:0]   addr,
  output logic          ready,
  output logic          rvalid,
  output logic [31:0]   rdata,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data
`ifdef IM_FETCH_CHECK_EN
  ,
  output logic          err
`endif
);

  state_t           state, next_state;
  logic [CNT_W-1:0] count;
  logic [AW-1:0]    addr_idx, idx_q, rd_idx;
  logic [31:0]      mem_word;
  logic             accept, enter_resp;

  // Byte offset from BASE turned into a word index; wraps modulo DEPTH.
  assign addr_idx   = AW'((addr - BASE) >> 2);
  assign accept     = (state == S_IDLE) && req;
  assign enter_resp = (next_state == S_RESP);

  // With LATENCY=0 the response is captured on the accepting edge, so the
  // read index must come straight from addr while idle.
  assign rd_idx = (state == S_IDLE) ? addr_idx : idx_q;

`ifdef IM_FETCH_CHECK_EN
  logic fault, fault_q, fault_sel;
  assign fault = (addr[1:0] != 2'b00) || (addr < BASE) ||
                 (((addr - BASE) >> 2) >= 32'(DEPTH));
  assign fault_sel = (state == S_IDLE) ? fault : fault_q;
`endif

  im_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (rd_idx),
    .rdata (mem_word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; requests outside IDLE are dropped, not queued.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          next_state = (LATENCY == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (count <= CNT_W'(1)) begin
          next_state = S_RESP;
        end
      end
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    ready  = (state == S_IDLE);
    rvalid = (state == S_RESP);
  end

  // Wait counter, captured fetch index and the registered response word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      idx_q <= '0;
      rdata <= '0;
`ifdef IM_FETCH_CHECK_EN
      fault_q <= 1'b0;
      err     <= 1'b0;
`endif
    end else begin
      if (accept) begin
        count <= CNT_W'(LATENCY);
        idx_q <= addr_idx;
`ifdef IM_FETCH_CHECK_EN
        fault_q <= fault;
`endif
      end else if ((state == S_WAIT) && (count != '0)) begin
        count <= count - CNT_W'(1);
      end
`ifdef IM_FETCH_CHECK_EN
      if (enter_resp) begin
        rdata <= fault_sel ? 32'h0 : mem_word;
      end
      err <= enter_resp && fault_sel;
`else
      if (enter_resp) begin
        rdata <= mem_word;
      end
`endif
    end
  end

endmodule

// File: tb/tb_im_responder.sv
// tb_im_responder
// Scoreboard bench for im_responder. Two instances share the clock, reset
// and program-load bus: dut_a uses LATENCY=2, dut_b uses LATENCY=0; both use
// DEPTH=16 and the default BASE. Expected responses (word, fault flag and
// the cycle they must appear in) are queued by the stimulus and consumed by
// per-instance monitors on the falling edge.
// Honours IM_FETCH_CHECK_EN to match the optional err port.
module tb_im_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 0;
  localparam int DEPTH = 16;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [31:0] prog_data;

  logic        req_a, ready_a, rvalid_a;
  logic [31:0] addr_a, rdata_a;
  logic        req_b, ready_b, rvalid_b;
  logic [31:0] addr_b, rdata_b;
`ifdef IM_FETCH_CHECK_EN
  logic        err_a, err_b;
`endif

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t cur_a, cur_b;

  logic [31:0] w [16] = '{
    32'h2008_0001, 32'h3C01_1001, 32'h8C22_0004, 32'hAC23_0008,
    32'h0000_000C, 32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D,
    32'h0840_0010, 32'h2129_FFFF, 32'h0150_4020, 32'h1000_FFFE,
    32'h3508_00FF, 32'h8FBF_0014, 32'h03E0_0008, 32'hF00D_CAFE
  };

  im_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .req       (req_a),
    .addr      (addr_a),
    .ready     (ready_a),
    .rvalid    (rvalid_a),
    .rdata     (rdata_a),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
`ifdef IM_FETCH_CHECK_EN
    ,
    .err       (err_a)
`endif
  );

  im_responder #(.DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .req       (req_b),
    .addr      (addr_b),
    .ready     (ready_b),
    .rvalid    (rvalid_b),
    .rdata     (rdata_b),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
`ifdef IM_FETCH_CHECK_EN
    ,
    .err       (err_b)
`endif
  );

  // 10 ns clock and a rising-edge cycle counter used for latency checks.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic push_a(input logic [31:0] d, input logic e, input int at);
    exp_t x;
    x.data = d;
    x.err  = e;
    x.cyc  = at;
    q_a.push_back(x);
  endtask

  task automatic push_b(input logic [31:0] d, input logic e, input int at);
    exp_t x;
    x.data = d;
    x.err  = e;
    x.cyc  = at;
    q_b.push_back(x);
  endtask

  task automatic prog_word(input logic [3:0] idx, input logic [31:0] d);
    @(posedge clk); #1;
    prog_we   = 1'b1;
    prog_addr = idx;
    prog_data = d;
    @(posedge clk); #1;
    prog_we   = 1'b0;
  endtask

  // One fetch on dut_a; with hold, req stays high (at another address)
  // through WAIT and RESP, and must be ignored.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] d,
                                input logic e, input bit hold);
    @(posedge clk); #1;
    req_a  = 1'b1;
    addr_a = a;
    push_a(d, e, cyc + LAT_A + 1);
    @(posedge clk); #1;
    if (hold) addr_a = 32'h0000_3008;
    else req_a = 1'b0;
    for (int i = 0; i < LAT_A + 1; i++) begin
      @(negedge clk);
      check_output("ready_a_busy", {31'b0, ready_a}, 32'd0);
    end
    req_a = 1'b0;
    @(negedge clk);
    check_output("ready_a_idle", {31'b0, ready_a}, 32'd1);
  endtask

  // Monitor for dut_a.
  always @(negedge clk) begin
    if (rvalid_a === 1'b1) begin
      if (q_a.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL unexpected_rvalid_a: got rvalid=1, expected 0 (cycle %0d)", cyc);
      end else begin
        cur_a = q_a.pop_front();
        check_output("rdata_a", rdata_a, cur_a.data);
        check_output("latency_a", cyc, cur_a.cyc);
`ifdef IM_FETCH_CHECK_EN
        check_output("err_a", {31'b0, err_a}, {31'b0, cur_a.err});
`endif
      end
    end
  end

  // Monitor for dut_b.
  always @(negedge clk) begin
    if (rvalid_b === 1'b1) begin
      if (q_b.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL unexpected_rvalid_b: got rvalid=1, expected 0 (cycle %0d)", cyc);
      end else begin
        cur_b = q_b.pop_front();
        check_output("rdata_b", rdata_b, cur_b.data);
        check_output("latency_b", cyc, cur_b.cyc);
`ifdef IM_FETCH_CHECK_EN
        check_output("err_b", {31'b0, err_b}, {31'b0, cur_b.err});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    req_a     = 1'b0;
    addr_a    = '0;
    req_b     = 1'b0;
    addr_b    = '0;

    // Program load while reset is held low.
    for (int i = 0; i < 16; i++) prog_word(4'(i), w[i]);
    @(negedge clk);
    check_output("reset_ready_a", {31'b0, ready_a}, 32'd1);
    check_output("reset_rvalid_a", {31'b0, rvalid_a}, 32'd0);
    check_output("reset_rdata_a", rdata_a, 32'd0);
    check_output("reset_ready_b", {31'b0, ready_b}, 32'd1);
    check_output("reset_rdata_b", rdata_b, 32'd0);
`ifdef IM_FETCH_CHECK_EN
    check_output("reset_err_a", {31'b0, err_a}, 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b1;

    // Basic fetch, then a fetch with req held through WAIT/RESP.
    apply_stimulus(32'h0000_3000, w[0], 1'b0, 1'b0);
    apply_stimulus(32'h0000_3004, w[1], 1'b0, 1'b1);
    apply_stimulus(32'h0000_303C, w[15], 1'b0, 1'b0);

    // Write word 5 on the edge entering RESP: old word returned.
    @(posedge clk); #1;
    req_a  = 1'b1;
    addr_a = 32'h0000_3014;
    push_a(w[5], 1'b0, cyc + LAT_A + 1);
    @(posedge clk); #1;
    req_a = 1'b0;
    @(posedge clk); #1;
    prog_we   = 1'b1;
    prog_addr = 4'd5;
    prog_data = 32'h0BAD_F00D;
    @(posedge clk); #1;
    prog_we = 1'b0;
    @(posedge clk);
    apply_stimulus(32'h0000_3014, 32'h0BAD_F00D, 1'b0, 1'b0);

    // Reset during WAIT aborts the fetch; a write during reset still lands.
    @(posedge clk); #1;
    req_a  = 1'b1;
    addr_a = 32'h0000_3004;
    @(posedge clk); #1;
    req_a     = 1'b0;
    reset     = 1'b0;
    prog_we   = 1'b1;
    prog_addr = 4'd7;
    prog_data = 32'h7777_0007;
    @(posedge clk); #1;
    reset   = 1'b1;
    prog_we = 1'b0;
    @(negedge clk);
    check_output("abort_ready_a", {31'b0, ready_a}, 32'd1);
    check_output("abort_rdata_a", rdata_a, 32'd0);
    check_output("abort_rvalid_a", {31'b0, rvalid_a}, 32'd0);
    repeat (4) @(posedge clk);
    apply_stimulus(32'h0000_3008, w[2], 1'b0, 1'b0);
    apply_stimulus(32'h0000_301C, 32'h7777_0007, 1'b0, 1'b0);

    // Out-of-range, misaligned and below-base addresses.
`ifdef IM_FETCH_CHECK_EN
    apply_stimulus(32'h0000_3040, 32'h0, 1'b1, 1'b0);
    apply_stimulus(32'h0000_3048, 32'h0, 1'b1, 1'b0);
    apply_stimulus(32'h0000_3002, 32'h0, 1'b1, 1'b0);
    apply_stimulus(32'h0000_2FFC, 32'h0, 1'b1, 1'b0);
`else
    apply_stimulus(32'h0000_3040, w[0], 1'b0, 1'b0);
    apply_stimulus(32'h0000_3048, w[2], 1'b0, 1'b0);
    apply_stimulus(32'h0000_3002, w[0], 1'b0, 1'b0);
    apply_stimulus(32'h0000_2FFC, w[15], 1'b0, 1'b0);
`endif
    apply_stimulus(32'h0000_3024, w[9], 1'b0, 1'b0);

    // dut_b (LATENCY=0): req held high, responses every second cycle.
    @(posedge clk); #1;
    req_b  = 1'b1;
    addr_b = 32'h0000_3004;
    push_b(w[1], 1'b0, cyc + LAT_B + 1);
    @(posedge clk); #1;
    addr_b = 32'h0000_3008;
    push_b(w[2], 1'b0, cyc + 2);
    @(negedge clk);
    check_output("ready_b_resp", {31'b0, ready_b}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("ready_b_idle", {31'b0, ready_b}, 32'd1);
    @(posedge clk); #1;
    req_b = 1'b0;
    @(negedge clk);
    check_output("ready_b_resp2", {31'b0, ready_b}, 32'd0);

    // Drain and confirm every expected response arrived.
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_output("pending_a", q_a.size(), 32'd0);
    check_output("pending_b", q_b.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
